// File: rtl/jk_updown_counter.sv
// ---------------------------------------------------------------------------
// jk_updown_counter
//
// Purpose:
//   Synchronous W-bit up/down counter built from one JK flip-flop cell per
//   bit. Each cell's J/K pair is derived from hold, parallel-load and
//   toggle equations. Provides count enable, direction control, a
//   combinational terminal-count output and a sticky wrap (overflow) flag.
//
// Configuration:
//   JK_CNT_MOD_EN  - when defined, the counter counts modulo MODULUS:
//                    wraps go to 0 / MODULUS-1 and loads of d >= MODULUS
//                    are clamped to MODULUS-1. When undefined the counter
//                    is a plain 2^W binary counter and MODULUS is ignored.
//
// Parameters:
//   W        counter width in bits (2..16)
//   MODULUS  count modulus, modulo build only (2..2^W)
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (q=0, ovf=0)
//   en    in   count enable
//   up    in   direction, 1 = increment, 0 = decrement
//   load  in   synchronous parallel load (priority over en)
//   d     in   parallel load value
//   q     out  counter state
//   qn    out  bitwise complement of q
//   tc    out  terminal count: en & (up ? q==MAX : q==0)
//   ovf   out  sticky wrap flag, cleared by rst or load
// ---------------------------------------------------------------------------
module jk_updown_counter #(
  parameter int W       = 4,
  parameter int MODULUS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] qn,
  output logic         tc,
  output logic         ovf
);

  // Elaboration-time legality of the configuration.
`ifdef JK_CNT_MOD_EN
  if (W < 2 || W > 16 || MODULUS < 2 || MODULUS > (1 << W)) begin : g_bad_cfg
    $error("jk_updown_counter: illegal W/MODULUS");
  end
  localparam logic [W-1:0] MAX_V = W'(MODULUS - 1);
  localparam logic [W:0]   MOD_V = (W+1)'(MODULUS);
`else
  if (W < 2 || W > 16 || MODULUS < 2) begin : g_bad_cfg
    $error("jk_updown_counter: illegal W/MODULUS");
  end
  localparam logic [W-1:0] MAX_V = '1;
`endif

  logic [W-1:0] q_q, q_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] j, k;
  logic [W-1:0] t_up, t_dn;
  logic [W-1:0] ld_val;
  logic         tc_w;

  // Value actually loaded; in the modulo build out-of-range loads saturate
  // to the top count so the state never leaves 0..MODULUS-1.
  function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
`ifdef JK_CNT_MOD_EN
    if ({1'b0, v} >= MOD_V) return MAX_V;
    else                    return v;
`else
    return v;
`endif
  endfunction

  assign ld_val = clamp_load(d);
  assign tc_w   = en & (up ? (q_q == MAX_V) : (q_q == '0));

  always_comb begin
    // Toggle terms: a bit flips when every lower bit is 1 (up) or 0 (down).
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < W; i++) begin
      t_up[i] = t_up[i-1] &  q_q[i-1];
      t_dn[i] = t_dn[i-1] & ~q_q[i-1];
    end

    j = '0;
    k = '0;
    if (load) begin
      j = ld_val;
      k = ~ld_val;
    end else if (en) begin
`ifdef JK_CNT_MOD_EN
      if (tc_w && up) begin
        // Up-wrap: clear every cell.
        j = '0;
        k = '1;
      end else if (tc_w && !up) begin
        // Down-wrap: load MODULUS-1 into the cells.
        j = MAX_V;
        k = ~MAX_V;
      end else begin
        j = up ? t_up : t_dn;
        k = up ? t_up : t_dn;
      end
`else
      j = up ? t_up : t_dn;
      k = up ? t_up : t_dn;
`endif
    end

    // JK cell characteristic equation, one cell per bit.
    q_d = (j & ~q_q) | (~k & q_q);

    if (load)      ovf_d = 1'b0;
    else if (tc_w) ovf_d = 1'b1;
    else           ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign qn  = ~q_q;
  assign tc  = tc_w;
  assign ovf = ovf_q;

endmodule
